serial_sub_ctrl: RTL and testbench
==================================

// Module: serial_sub_ctrl
// PURPOSE
//  Bit-serial multi-bit subtraction controller built around one full_subtractor cell.
//  - Accepts two WIDTH-bit operands and a borrow-in on a start strobe.
//  - Feeds one operand bit-pair per clock, LSB first, through the shared cell, and holds the borrow in a flip-flop.
//  - Returns the difference and borrow-out with a one-cycle done pulse.
//  - Serves as the arithmetic sequencer wherever area matters more than latency.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 2..32
// PORTS
//  clk     in   1      single clock; all state updates on rising edge
//  rst     in   1      synchronous, active-high reset
//  start   in   1      request; sampled only in IDLE
//  a       in   WIDTH  minuend; captured on the accepted start edge
//  b       in   WIDTH  subtrahend; captured on the accepted start edge
//  bin     in   1      borrow-in; captured on the accepted start edge
//  busy    out  1      high while in RUN
//  done    out  1      one-cycle pulse; high exactly in the DONE state
//  diff    out  WIDTH  result register: a - b - bin, modulo 2^WIDTH
//  bout    out  1      final borrow-out (1 when a < b + bin, unsigned)
// BEHAVIOUR
//  - Reset (rst=1 at an edge, any state, including mid-RUN):
//    - state=IDLE; busy=0, done=0, diff=0, bout=0.
//    - Shift registers, borrow FF and bit counter all cleared.
//    - An in-flight operation is discarded with no done pulse.
//  - FSM states: IDLE, RUN, DONE.
//    - IDLE --start=1--> RUN: load a_sh<=a, b_sh<=b, brw<=bin, cnt<=0.
//    - RUN, each edge:
//      - cell inputs a_sh[0], b_sh[0], brw.
//      - d_sh <= {cell.diff, d_sh[WIDTH-1:1]}; brw <= cell.borrow.
//      - a_sh and b_sh shift right by one; cnt <= cnt+1.
//    - RUN with cnt==WIDTH-1 --> DONE:
//      - on that same edge, diff <= {cell.diff, d_sh[WIDTH-1:1]} and bout <= cell.borrow.
//    - DONE --> IDLE unconditionally at the next edge.
//  - Latency: start sampled at edge E0; done=1 during the cycle after edge E0+WIDTH.
//  - Throughput: one operation per WIDTH+2 cycles.
//  - start is ignored in RUN and DONE; operands presented then are not captured.
//    - A start held high continuously is re-accepted in the first IDLE cycle.
//  - diff/bout change only on the last RUN edge or on reset.
//    - They hold the previous result stable throughout the following operation.
//  - cnt width is $clog2(WIDTH); it never exceeds WIDTH-1 and does not wrap.
//  - Unused state encoding: return to IDLE next edge with outputs unchanged.
//  - No combinational path from any input to any output; busy/done decode from the state register only.
// STRUCTURE
//  - Shared package serial_arith_pkg holds:
//    - state encodings SA_IDLE=2'd0, SA_RUN=2'd1, SA_DONE=2'd2.
//    - WIDTH legality bounds; reused by future serial adder/comparator controllers.
//  - One sub-module instance: full_subtractor (ports a, b, c, diff, borrow), driven from the LSBs and brw.
//  - Remainder in this file:
//    - FSM register + next-state logic.
//    - Three WIDTH-bit shift registers, borrow FF, bit counter, result registers.
// TESTING (WIDTH=8 unless noted; check every cycle against a reference model)
//  1. rst held 2 cycles -> busy=0, done=0, diff=0x00, bout=0.
//     Pulse start with a=0x5A, b=0x23, bin=0 -> busy next cycle; done exactly one cycle after edge E0+8; diff=0x37, bout=0.
//  2. a=0x10, b=0x20, bin=0 -> diff=0xF0, bout=1.
//     a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
//     a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
//  3. Start a=0x80, b=0x01; re-pulse start with a=0x00, b=0xFF at RUN cycle 3 -> second request ignored; diff=0x7F, bout=0.
//     diff stays at the prior result until that done.
//  4. Start a=0xAA, b=0x55; assert rst at RUN cycle 4 -> after that edge busy=0, diff=0x00; no done pulse.
//     A following start with a=0x03, b=0x01 -> diff=0x02.
//  5. start held high for 30 cycles, operands fixed a=0x09, b=0x04 -> done pulses every 10 cycles; diff=0x05 each time.
//  6. WIDTH=2, exhaustive a, b, bin (32 cases) -> diff/bout match {bout, diff} = a - b - bin (mod 8); latency 2.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic controllers (subtractor today,
// adder/comparator later): FSM encodings and legal operand-width bounds.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_RUN  = 2'd1,
    SA_DONE = 2'd2
  } sa_state_e;

  localparam int SA_WIDTH_MIN = 2;
  localparam int SA_WIDTH_MAX = 32;

  function automatic bit sa_width_legal(input int w);
    return (w >= SA_WIDTH_MIN) && (w <= SA_WIDTH_MAX);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - c, borrow set when a < b + c.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ c;
  assign borrow = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one operand bit-pair per clock, LSB first,
// through a single full_subtractor cell with the borrow held in a flop.
module serial_sub_ctrl
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic             brw_q, brw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic cell_diff;
  logic cell_borrow;

  full_subtractor u_cell (
    .a      (a_sh_q[0]),
    .b      (b_sh_q[0]),
    .c      (brw_q),
    .diff   (cell_diff),
    .borrow (cell_borrow)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    d_sh_d  = d_sh_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      SA_IDLE: begin
        if (start) begin
          state_d = SA_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
        end
      end
      SA_RUN: begin
        d_sh_d = {cell_diff, d_sh_q[WIDTH-1:1]};
        brw_d  = cell_borrow;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        // Counter parks on the last bit index instead of wrapping.
        if (cnt_q == CNT_LAST) begin
          state_d = SA_DONE;
          diff_d  = {cell_diff, d_sh_q[WIDTH-1:1]};
          bout_d  = cell_borrow;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SA_DONE: state_d = SA_IDLE;
      default: state_d = SA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SA_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      d_sh_q  <= d_sh_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q == SA_RUN);
  assign done = (state_q == SA_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed + random bench for serial_sub_ctrl at WIDTH=8 and WIDTH=2, with a
// result queue per instance and a per-cycle check that results hold between dones.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       bin2 = 1'b0;
  logic       busy2, done2, bout2;
  logic [1:0] diff2;

  logic [8:0] exp_q[$];
  logic [2:0] exp2_q[$];
  logic [8:0] held8 = '0;
  logic [2:0] held2 = '0;

  int total = 0;
  int bad   = 0;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_sub_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1ns later, retire any done against the queues.
  task automatic tick();
    logic [8:0] e8;
    logic [2:0] e2;
    @(posedge clk);
    #1;
    if (done8) begin
      if (exp_q.size() == 0) chk("w8_done_without_request", 32'(done8), 32'd0);
      else begin
        e8 = exp_q.pop_front();
        chk("w8_result", {23'd0, bout8, diff8}, {23'd0, e8});
        held8 = e8;
      end
    end else begin
      chk("w8_hold", {23'd0, bout8, diff8}, {23'd0, held8});
    end
    if (done2) begin
      if (exp2_q.size() == 0) chk("w2_done_without_request", 32'(done2), 32'd0);
      else begin
        e2 = exp2_q.pop_front();
        chk("w2_result", {29'd0, bout2, diff2}, {29'd0, e2});
        held2 = e2;
      end
    end else begin
      chk("w2_hold", {29'd0, bout2, diff2}, {29'd0, held2});
    end
  endtask

  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {8'd0, c};
  endfunction

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c);
    exp_q.push_back(ref8(x, y, c));
    a8 = x; b8 = y; bin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("w8_busy_after_start", 32'(busy8), 32'd1);
    repeat (7) begin
      tick();
      chk("w8_busy_run", 32'(busy8), 32'd1);
      chk("w8_done_early", 32'(done8), 32'd0);
    end
    tick();
    chk("w8_done_latency", 32'(done8), 32'd1);
    chk("w8_busy_in_done", 32'(busy8), 32'd0);
    tick();
    chk("w8_done_one_cycle", 32'(done8), 32'd0);
    chk("w8_idle_busy", 32'(busy8), 32'd0);
  endtask

  task automatic op2(input logic [1:0] x, input logic [1:0] y, input logic c);
    exp2_q.push_back({1'b0, x} - {1'b0, y} - {2'd0, c});
    a2 = x; b2 = y; bin2 = c; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("w2_busy_after_start", 32'(busy2), 32'd1);
    tick();
    chk("w2_done_early", 32'(done2), 32'd0);
    tick();
    chk("w2_done_latency", 32'(done2), 32'd1);
    tick();
    chk("w2_done_one_cycle", 32'(done2), 32'd0);
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_bout", 32'(bout8), 32'd0);
    rst = 1'b0;
    tick();

    // basic and borrow cases
    op8(8'h5A, 8'h23, 1'b0);
    chk("t1_diff", 32'(diff8), 32'h37);
    op8(8'h10, 8'h20, 1'b0);
    chk("t2a_diff", 32'(diff8), 32'hF0);
    chk("t2a_bout", 32'(bout8), 32'd1);
    op8(8'h00, 8'h00, 1'b1);
    chk("t2b_diff", 32'(diff8), 32'hFF);
    op8(8'hFF, 8'hFF, 1'b1);
    chk("t2c_bout", 32'(bout8), 32'd1);

    // start during RUN is ignored; prior result held until done
    exp_q.push_back(ref8(8'h80, 8'h01, 1'b0));
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    chk("t3_not_done_yet", 32'(done8), 32'd0);
    tick();
    chk("t3_done", 32'(done8), 32'd1);
    chk("t3_diff", 32'(diff8), 32'h7F);
    tick();
    tick();
    chk("t3_second_ignored", 32'(busy8), 32'd0);

    // reset mid-RUN discards the operation
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    held8 = '0;
    tick();
    rst = 1'b0;
    chk("t4_busy_cleared", 32'(busy8), 32'd0);
    chk("t4_diff_cleared", 32'(diff8), 32'd0);
    repeat (10) begin
      tick();
      chk("t4_no_done", 32'(done8), 32'd0);
    end
    op8(8'h03, 8'h01, 1'b0);
    chk("t4_diff", 32'(diff8), 32'h02);

    // start held high: back-to-back every WIDTH+2 cycles
    repeat (3) exp_q.push_back(ref8(8'h09, 8'h04, 1'b0));
    a8 = 8'h09; b8 = 8'h04; bin8 = 1'b0; start8 = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk("t5_done_cadence", 32'(done8), 32'((k % 10) == 9));
    end
    start8 = 1'b0;
    tick();
    chk("t5_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("t5_idle", 32'(busy8), 32'd0);

    // random operands
    for (int r = 0; r < 6; r++)
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    // WIDTH=2 exhaustive
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int c = 0; c < 2; c++)
          op2(2'(i), 2'(j), 1'(c));
    chk("t6_queue_drained", 32'(exp2_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
